// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles everything that passes between the two LC-3 requesters, the
// memory arbiter and the single-port memory.
//
// Requester port 0 (instruction fetch) and port 1 (data access):
//   reqN    requester -> arbiter   request, held until gntN is seen
//   weN     requester -> arbiter   1 = write, 0 = read
//   addrN   requester -> arbiter   access address (AW bits)
//   wdataN  requester -> arbiter   write data (DW bits)
//   gntN    arbiter -> requester   one-cycle grant pulse
//   doneN   arbiter -> requester   one-cycle completion pulse
//   rdataN  arbiter -> requester   last read data returned to this port
//
// Memory side:
//   mem_en     arbiter -> memory   enable, high for the whole access
//   mem_rw     arbiter -> memory   1 = write
//   mem_addr   arbiter -> memory   address
//   mem_wdata  arbiter -> memory   write data
//   mem_rdata  memory -> arbiter   read data, valid at the final access edge
//
// Modports:
//   slave   the arbiter's view
//   master  the view of whatever drives requests and models the memory
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);

   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          gnt0;
   logic          done0;
   logic [DW-1:0] rdata0;

   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          gnt1;
   logic          done1;
   logic [DW-1:0] rdata1;

   logic          mem_en;
   logic          mem_rw;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_rdata,
      output gnt0, done0, rdata0,
      output gnt1, done1, rdata1,
      output mem_en, mem_rw, mem_addr, mem_wdata
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_rdata,
      input  gnt0, done0, rdata0,
      input  gnt1, done1, rdata1,
      input  mem_en, mem_rw, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-port LC-3 memory between instruction fetch (port 0)
// and data access (port 1).  A request seen in IDLE is granted for one
// fixed-length access: mem_en is held for MEM_LAT cycles, then a one-cycle
// RESP state pulses done for the winning port and, for reads, presents the
// captured memory data on that port's rdata.  When both ports request in
// the same IDLE cycle the port that was not granted last wins, so
// continuous traffic on both ports alternates strictly.
//
// Parameters:
//   MEM_LAT  cycles mem_en is held high per access (>= 1)
//   AW, DW   address / data width; must match the interface instance
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_arbiter_if.slave: both requester ports and the memory pins
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int MEM_LAT = 2,
   parameter int AW      = 16,
   parameter int DW      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   // A one-cycle access still needs a one-bit counter that simply sits at 0.
   localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } arbState_t;

   arbState_t     state_q,     state_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   logic          lastGrant_q, lastGrant_d;
   logic          winner_q,    winner_d;
   logic          gnt0_q,      gnt0_d;
   logic          gnt1_q,      gnt1_d;
   logic          done0_q,     done0_d;
   logic          done1_q,     done1_d;
   logic          memEn_q,     memEn_d;
   logic          memRw_q,     memRw_d;
   logic [AW-1:0] memAddr_q,   memAddr_d;
   logic [DW-1:0] memWdata_q,  memWdata_d;
   logic [DW-1:0] rdata0_q,    rdata0_d;
   logic [DW-1:0] rdata1_q,    rdata1_d;
   logic          pick;

   // Next-state and output logic.  Everything defaults to holding its
   // value except the gnt/done pulses, which default low so that each one
   // lasts exactly one cycle.  Requests are only looked at in IDLE, which is
   // what makes a double grant impossible while an access is in flight.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lastGrant_d = lastGrant_q;
      winner_d    = winner_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      memEn_d     = memEn_q;
      memRw_d     = memRw_q;
      memAddr_d   = memAddr_q;
      memWdata_d  = memWdata_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      pick        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // On a tie the port that lost last time goes next; with a
               // single requester req1 alone names the winner.
               if (bus.req0 && bus.req1) begin
                  pick = ~lastGrant_q;
               end else begin
                  pick = bus.req1;
               end
               winner_d    = pick;
               lastGrant_d = pick;
               memEn_d     = 1'b1;
               memRw_d     = pick ? bus.we1    : bus.we0;
               memAddr_d   = pick ? bus.addr1  : bus.addr0;
               memWdata_d  = pick ? bus.wdata1 : bus.wdata0;
               gnt0_d      = ~pick;
               gnt1_d      = pick;
               cnt_d       = CNT_INIT;
               state_d     = ACCESS;
            end
         end

         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // Final access edge: mem_rdata is valid now, so a read is
               // captured into the winner's rdata; writes leave it alone.
               memEn_d = 1'b0;
               memRw_d = 1'b0;
               if (!memRw_q) begin
                  if (winner_q) begin
                     rdata1_d = bus.mem_rdata;
                  end else begin
                     rdata0_d = bus.mem_rdata;
                  end
               end
               done0_d = ~winner_q;
               done1_d = winner_q;
               state_d = RESP;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.  Reset is asynchronous so that mem_en
   // drops the moment rst_n falls, abandoning any access in progress.
   // lastGrant resets to port 1 so fetch wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         lastGrant_q <= 1'b1;
         winner_q    <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         memEn_q     <= 1'b0;
         memRw_q     <= 1'b0;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lastGrant_q <= lastGrant_d;
         winner_q    <= winner_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
         memEn_q     <= memEn_d;
         memRw_q     <= memRw_d;
         memAddr_q   <= memAddr_d;
         memWdata_q  <= memWdata_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   // Every output comes straight from a register.
   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.done0     = done0_q;
   assign bus.done1     = done1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.mem_en    = memEn_q;
   assign bus.mem_rw    = memRw_q;
   assign bus.mem_addr  = memAddr_q;
   assign bus.mem_wdata = memWdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiters are exercised: dutA with MEM_LAT=2 and dutB with MEM_LAT=1,
// each with its own interface, reset and behavioural memory.  Each issued
// request pushes its expected grant cycle, done cycle and rdata into a
// scoreboard; a monitor running on the falling edge checks grants, the
// memory pins during the access and the response when done appears.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;

   logic clk;
   logic rstA_n;
   logic rstB_n;

   mem_arbiter_if #(.AW(AW), .DW(DW)) ifA ();
   mem_arbiter_if #(.AW(AW), .DW(DW)) ifB ();

   mem_arbiter #(.MEM_LAT(2), .AW(AW), .DW(DW)) dutA (
      .clk   (clk),
      .rst_n (rstA_n),
      .bus   (ifA.slave)
   );

   mem_arbiter #(.MEM_LAT(1), .AW(AW), .DW(DW)) dutB (
      .clk   (clk),
      .rst_n (rstB_n),
      .bus   (ifB.slave)
   );

   typedef struct {
      int            dut;
      int            port;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] expRdata;
      int            gntCyc;
      int            doneCyc;
   } expEntry_t;

   expEntry_t     sb[$];
   expEntry_t     cur[2];
   bit            inAcc[2];
   int            enCnt[2];
   int            vectors     = 0;
   int            miscompares = 0;
   int            cyc         = 0;
   int            base        = 0;

   logic [DW-1:0] memA [0:65535];
   bit            wrA  [0:65535];
   logic [DW-1:0] memB [0:65535];
   bit            wrB  [0:65535];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: the value seen at a falling edge names the current cycle.
   always @(posedge clk) cyc <= cyc + 1;

   // Contents of memory locations nobody has written yet.
   function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
      case (a)
         16'h3000: return 16'h1234;
         16'h3001: return 16'h5678;
         16'h0000: return 16'hA5A5;
         16'h0001: return 16'h5A5A;
         default:  return a ^ 16'hFFFF;
      endcase
   endfunction

   // Behavioural memories: combinational read, write on the clock edge
   // while the arbiter holds mem_en with mem_rw set.
   always_comb ifA.mem_rdata = wrA[ifA.mem_addr] ? memA[ifA.mem_addr] : initVal(ifA.mem_addr);
   always_comb ifB.mem_rdata = wrB[ifB.mem_addr] ? memB[ifB.mem_addr] : initVal(ifB.mem_addr);

   always @(posedge clk) begin
      if (ifA.mem_en && ifA.mem_rw) begin
         memA[ifA.mem_addr] <= ifA.mem_wdata;
         wrA[ifA.mem_addr]  <= 1'b1;
      end
      if (ifB.mem_en && ifB.mem_rw) begin
         memB[ifB.mem_addr] <= ifB.mem_wdata;
         wrB[ifB.mem_addr]  <= 1'b1;
      end
   end

   function automatic int lat(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flagFail(input string name, input string what);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: %s", name, what);
   endtask

   task automatic setReq(input int d, input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
      if (d == 0 && p == 0) begin
         ifA.req0 = r; ifA.we0 = w; ifA.addr0 = a; ifA.wdata0 = wd;
      end else if (d == 0) begin
         ifA.req1 = r; ifA.we1 = w; ifA.addr1 = a; ifA.wdata1 = wd;
      end else if (p == 0) begin
         ifB.req0 = r; ifB.we0 = w; ifB.addr0 = a; ifB.wdata0 = wd;
      end else begin
         ifB.req1 = r; ifB.we1 = w; ifB.addr1 = a; ifB.wdata1 = wd;
      end
   endtask

   function automatic logic getGnt(input int d, input int p);
      if (d == 0) return (p == 0) ? ifA.gnt0 : ifA.gnt1;
      return (p == 0) ? ifB.gnt0 : ifB.gnt1;
   endfunction

   function automatic int findEntry(input int d, input int p);
      foreach (sb[i]) begin
         if (sb[i].dut == d && sb[i].port == p) return i;
      end
      return -1;
   endfunction

   // Issue one request at the current falling edge and hold it until the
   // grant is seen.  gntOff is the hand-computed grant cycle relative to
   // base; the response is expected MEM_LAT cycles after the grant.
   task automatic applyStimulus(input int d, input int p, input bit w,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [DW-1:0] expRd, input int gntOff);
      expEntry_t e;
      bit        granted;
      e.dut      = d;
      e.port     = p;
      e.we       = w;
      e.addr     = a;
      e.wdata    = wd;
      e.expRdata = expRd;
      e.gntCyc   = base + gntOff;
      e.doneCyc  = base + gntOff + lat(d);
      sb.push_back(e);
      setReq(d, p, 1'b1, w, a, wd);
      granted = 1'b0;
      for (int i = 0; i < 40 && !granted; i++) begin
         @(negedge clk);
         if (getGnt(d, p)) granted = 1'b1;
      end
      if (!granted) flagFail($sformatf("dut%0d port%0d grant", d, p), "no grant within 40 cycles");
      setReq(d, p, 1'b0, 1'b0, '0, '0);
   endtask

   // Drop a DUT's outstanding expectations when its reset is asserted.
   task automatic flush(input int d);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].dut == d) sb.delete(i);
      end
      inAcc[d] = 1'b0;
   endtask

   // One monitor step for one DUT, called on every falling edge.
   task automatic monStep(input int d, input logic g0, input logic g1,
                          input logic dn0, input logic dn1, input logic en, input logic rw,
                          input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
                          input logic [DW-1:0] r0, input logic [DW-1:0] r1);
      int        idx;
      int        p;
      string     tag;
      expEntry_t e;
      tag = (d == 0) ? "A" : "B";
      if (g0 || g1 || dn0 || dn1) begin
         checkOutput({tag, " gnt/done exclusive"}, 64'($countones({g0, g1, dn0, dn1})), 64'd1);
      end
      if (g0 || g1) begin
         p   = g1 ? 1 : 0;
         idx = findEntry(d, p);
         if (idx < 0) begin
            flagFail($sformatf("%s port%0d gnt", tag, p), "unexpected grant");
         end else begin
            cur[d]   = sb[idx];
            inAcc[d] = 1'b1;
            enCnt[d] = 0;
            checkOutput($sformatf("%s port%0d gnt cycle", tag, p), 64'(cyc), 64'(cur[d].gntCyc));
         end
      end
      if (inAcc[d] && !(dn0 || dn1)) begin
         e = cur[d];
         checkOutput($sformatf("%s port%0d mem pins {en,rw,addr,wdata}", tag, e.port),
                     {30'd0, en, rw, ma, (e.we ? mwd : 16'h0000)},
                     {30'd0, 1'b1, e.we, e.addr, (e.we ? e.wdata : 16'h0000)});
         enCnt[d]++;
      end
      if (dn0 || dn1) begin
         p   = dn1 ? 1 : 0;
         idx = findEntry(d, p);
         if (idx < 0) begin
            flagFail($sformatf("%s port%0d done", tag, p), "unexpected done");
         end else begin
            e = sb[idx];
            checkOutput($sformatf("%s port%0d done cycle", tag, p), 64'(cyc), 64'(e.doneCyc));
            checkOutput($sformatf("%s port%0d rdata", tag, p), 64'(p ? r1 : r0), 64'(e.expRdata));
            checkOutput($sformatf("%s port%0d mem_en cycles", tag, p), 64'(enCnt[d]), 64'(lat(d)));
            checkOutput($sformatf("%s port%0d {mem_en,mem_rw} in RESP", tag, p), {62'd0, en, rw}, 64'd0);
            sb.delete(idx);
         end
         inAcc[d] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      monStep(0, ifA.gnt0, ifA.gnt1, ifA.done0, ifA.done1, ifA.mem_en, ifA.mem_rw,
              ifA.mem_addr, ifA.mem_wdata, ifA.rdata0, ifA.rdata1);
      monStep(1, ifB.gnt0, ifB.gnt1, ifB.done0, ifB.done1, ifB.mem_en, ifB.mem_rw,
              ifB.mem_addr, ifB.mem_wdata, ifB.rdata0, ifB.rdata1);
   end

   // Watchdog so a stuck handshake can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      rstA_n = 1'b0;
      rstB_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) setReq(d, p, 1'b0, 1'b0, '0, '0);
      end
      repeat (3) @(negedge clk);

      // Reset values
      checkOutput("A reset {gnt0,gnt1,done0,done1,mem_en,mem_rw}",
                  {58'd0, ifA.gnt0, ifA.gnt1, ifA.done0, ifA.done1, ifA.mem_en, ifA.mem_rw}, 64'd0);
      checkOutput("A reset mem_addr", 64'(ifA.mem_addr), 64'd0);
      checkOutput("A reset mem_wdata", 64'(ifA.mem_wdata), 64'd0);
      checkOutput("A reset rdata0", 64'(ifA.rdata0), 64'd0);
      checkOutput("A reset rdata1", 64'(ifA.rdata1), 64'd0);
      checkOutput("B reset mem_en", 64'(ifB.mem_en), 64'd0);
      rstA_n = 1'b1;
      rstB_n = 1'b1;
      repeat (2) @(negedge clk);

      // Tie right after reset: fetch first, data one access later
      base = cyc;
      fork
         applyStimulus(0, 0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1);
         applyStimulus(0, 1, 1'b0, 16'h3001, 16'h0000, 16'h5678, 5);
      join
      repeat (4) @(negedge clk);

      // Lone port 0 read
      base = cyc;
      applyStimulus(0, 0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1);
      repeat (4) @(negedge clk);

      // Port 1 write leaves rdata1 alone, then reads the value back
      base = cyc;
      applyStimulus(0, 1, 1'b1, 16'h3005, 16'hBEEF, 16'h5678, 1);
      repeat (4) @(negedge clk);
      base = cyc;
      applyStimulus(0, 1, 1'b0, 16'h3005, 16'h0000, 16'hBEEF, 1);
      repeat (4) @(negedge clk);

      // Both ports continuously busy for six accesses: 0,1,0,1,0,1
      base = cyc;
      fork
         begin
            applyStimulus(0, 0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1);
            applyStimulus(0, 0, 1'b0, 16'h3001, 16'h0000, 16'h5678, 9);
            applyStimulus(0, 0, 1'b0, 16'h3005, 16'h0000, 16'hBEEF, 17);
         end
         begin
            applyStimulus(0, 1, 1'b0, 16'h3005, 16'h0000, 16'hBEEF, 5);
            applyStimulus(0, 1, 1'b1, 16'h3010, 16'hCAFE, 16'hBEEF, 13);
            applyStimulus(0, 1, 1'b0, 16'h3010, 16'h0000, 16'hCAFE, 21);
         end
      join
      repeat (4) @(negedge clk);

      // Reset in the second access cycle of a port 0 read
      base = cyc;
      applyStimulus(0, 0, 1'b0, 16'h3001, 16'h0000, 16'h5678, 1);
      @(negedge clk);
      #2;
      rstA_n = 1'b0;
      #1;
      checkOutput("A mem_en after async reset", 64'(ifA.mem_en), 64'd0);
      flush(0);
      repeat (2) @(negedge clk);
      checkOutput("A rdata0 cleared by reset", 64'(ifA.rdata0), 64'd0);
      rstA_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("A done0 after aborted access", 64'(ifA.done0), 64'd0);

      // Re-issue after reset; the tie again goes to port 0 first
      base = cyc;
      fork
         applyStimulus(0, 0, 1'b0, 16'h3001, 16'h0000, 16'h5678, 1);
         applyStimulus(0, 1, 1'b0, 16'h3010, 16'h0000, 16'hCAFE, 5);
      join
      repeat (4) @(negedge clk);

      // MEM_LAT=1: back-to-back port 0 reads three cycles apart
      base = cyc;
      applyStimulus(1, 0, 1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1);
      applyStimulus(1, 0, 1'b0, 16'h0001, 16'h0000, 16'h5A5A, 4);
      repeat (4) @(negedge clk);
      base = cyc;
      applyStimulus(1, 1, 1'b1, 16'h0002, 16'h1111, 16'h0000, 1);
      repeat (4) @(negedge clk);
      base = cyc;
      applyStimulus(1, 1, 1'b0, 16'h0002, 16'h0000, 16'h1111, 1);
      repeat (5) @(negedge clk);

      foreach (sb[i]) begin
         flagFail($sformatf("dut%0d port%0d response", sb[i].dut, sb[i].port), "expected done never seen");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port LC-3 memory between two requesters: port 0 is instruction fetch and port 1 is data access (LD/LDI/LDR/ST).
- Sequences the memory's mem_en/mem_rw pins over a fixed MEM_LAT-cycle access.
- Returns read data through a per-port done pulse.
- Replaces the hand-timed memory waits in the control unit with a synthesizable handshake.

Parameters:
MEM_LAT, 2, memory access cycles with mem_en held high; legal range >= 1
AW, 16, address width
DW, 16, data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  port 0 (fetch) request
we0  in  1  port 0 write enable (1 = write)
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
gnt0  out  1  port 0 grant pulse
done0  out  1  port 0 completion pulse
rdata0  out  DW  port 0 read data
req1/we1/addr1/wdata1/gnt1/done1/rdata1  same as port 0, for port 1 (data)
mem_en  out  1  memory enable
mem_rw  out  1  memory direction (1 = write)
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid at the final ACCESS edge

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt*, done*, mem_en, mem_rw = 0.
  - mem_addr, mem_wdata, rdata0, rdata1 = 0.
  - last_grant=1, so port 0 wins the first tie.
- States:
  - IDLE: waits for a request.
  - ACCESS: counter cnt runs MEM_LAT-1 down to 0.
  - RESP: one cycle.
- IDLE, at a clock edge with req0|req1 high:
  - Pick the winner: the sole requester, or, if both request, the port != last_grant.
  - Register the winner's we/addr/wdata into mem_rw/mem_addr/mem_wdata.
  - Set mem_en=1, gnt_winner=1, last_grant=winner, cnt=MEM_LAT-1; go to ACCESS.
- Handshake, requester side:
  - req, we, addr and wdata stay stable from assertion until gnt is seen high.
  - The requester drops req (or presents a new request) in the cycle after gnt.
- gnt is a one-cycle pulse in the first ACCESS cycle. The arbiter ignores req0 and req1 in ACCESS and RESP, so no double grant is possible.
- ACCESS:
  - mem_en, mem_rw, mem_addr and mem_wdata are held constant.
  - At an edge with cnt!=0: cnt decrements.
  - At an edge with cnt==0: mem_en=0 and mem_rw=0; for a read, rdata_winner <= mem_rdata; done_winner=1; go to RESP.
- RESP:
  - done is high for exactly this cycle.
  - At the next edge: done=0; go to IDLE.
- rdata retains its last value between reads and is unchanged by writes. done pulses for writes too.
- Latency:
  - req sampled at edge N.
  - gnt and mem_en are high from cycle N+1.
  - mem_en is high for cycles N+1..N+MEM_LAT.
  - done is high in cycle N+MEM_LAT+1.
- Throughput: one access per MEM_LAT+2 cycles. A request held through RESP is sampled in IDLE at the following edge.
- Fairness: under continuous requests on both ports, grants strictly alternate. A single active port is granted every access with no penalty.
- Reset mid-ACCESS: mem_en drops immediately and asynchronously, no done is issued, the pending access is lost, and the requester must re-issue.
- Only one of gnt0/gnt1 is high in any cycle, and likewise only one of done0/done1.
- MEM_LAT=1: ACCESS lasts exactly one cycle, and gnt and done are never high in the same cycle.

Test Plan:
- Port 0 read, MEM_LAT=2, addr0=0x3000, memory holds 0x1234:
  - gnt0 high at N+1.
  - mem_en high at N+1..N+2.
  - done0 high at N+3 with rdata0=0x1234.
- Port 1 write, addr1=0x3005, wdata1=0xBEEF:
  - mem_rw=1, mem_addr=0x3005, mem_wdata=0xBEEF throughout ACCESS.
  - done1 pulses at N+3.
  - A later read of 0x3005 returns 0xBEEF; rdata1 is unchanged by the write.
- req0 and req1 raised at the same edge after reset:
  - port 0 is granted first, and port 1 is granted at the edge after done0.
  - gnt0 and gnt1 are never high together.
- Both ports requesting continuously for 6 accesses: grant order is 0,1,0,1,0,1, and each access spans 4 cycles.
- rst_n pulled low in the second ACCESS cycle of a port 0 read:
  - mem_en falls immediately and done0 never asserts.
  - After release, state is IDLE, and a re-issued read completes normally.
- MEM_LAT=1, back-to-back port 0 reads of 0x0000 then 0x0001:
  - done0 fires 2 cycles after each sample.
  - Accesses are spaced 3 cycles apart, and rdata0 updates correctly each time.
